// File: rtl/vc_out_arbiter.sv
// Wormhole round-robin arbiter sharing one registered output flit channel among
// N_VIRT_CHN virtual-channel buffers; a HEAD locks the channel until its TAIL.

module vc_out_arbiter_lane #(
  parameter int IDX = 0,
  parameter int PW  = 1
) (
  input  logic          vld,
  input  logic [PW-1:0] rr_ptr,
  output logic          req_hi
);
  // Requests at or above the round-robin pointer win over wrapped-around ones.
  assign req_hi = vld && (IDX >= int'(rr_ptr));
endmodule

module vc_out_arbiter #(
  parameter int N_VIRT_CHN = 2,
  parameter int FLIT_WIDTH = 34
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] fin_data_i,
  input  logic [N_VIRT_CHN-1:0]            fin_valid_i,
  output logic [N_VIRT_CHN-1:0]            fin_ready_o,
  output logic [FLIT_WIDTH-1:0]            flit_data_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [$clog2(N_VIRT_CHN)-1:0]    vc_id_o,
  output logic                             err_o
);
  localparam int PW = $clog2(N_VIRT_CHN);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [1:0] F_HEAD = 2'b00;
  localparam logic [1:0] F_BODY = 2'b01;
  localparam logic [1:0] F_TAIL = 2'b10;
  localparam logic [1:0] F_HT   = 2'b11;

  logic [0:0]            state;
  logic [PW-1:0]         rr_ptr, lock_vc, gnt, gnt_inc;
  logic                  gnt_vld, out_free, acc;
  logic [N_VIRT_CHN-1:0] req_hi;
  logic [FLIT_WIDTH-1:0] flit;
  logic [1:0]            ftype;

  genvar gi;
  generate
    for (gi = 0; gi < N_VIRT_CHN; gi++) begin : g_lane
      vc_out_arbiter_lane #(.IDX(gi), .PW(PW)) u_lane (
        .vld    (fin_valid_i[gi]),
        .rr_ptr (rr_ptr),
        .req_hi (req_hi[gi])
      );
    end
  endgenerate

  // In IDLE the pick is combinational; a lock grants its VC even when not valid.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    if (state == LOCKED) begin
      gnt     = lock_vc;
      gnt_vld = 1'b1;
    end else begin
      for (int i = 0; i < N_VIRT_CHN; i++)
        if (!gnt_vld && req_hi[i]) begin
          gnt     = PW'(i);
          gnt_vld = 1'b1;
        end
      for (int i = 0; i < N_VIRT_CHN; i++)
        if (!gnt_vld && fin_valid_i[i]) begin
          gnt     = PW'(i);
          gnt_vld = 1'b1;
        end
    end
  end

  assign out_free = !valid_o || ready_i;

  always_comb begin
    fin_ready_o = '0;
    for (int i = 0; i < N_VIRT_CHN; i++)
      fin_ready_o[i] = gnt_vld && out_free && !arst && (gnt == PW'(i));
  end

  always_comb begin
    flit = '0;
    for (int i = 0; i < N_VIRT_CHN; i++)
      if (gnt == PW'(i)) flit = fin_data_i[i*FLIT_WIDTH +: FLIT_WIDTH];
  end

  assign acc     = |(fin_ready_o & fin_valid_i);
  assign ftype   = flit[FLIT_WIDTH-1:FLIT_WIDTH-2];
  assign gnt_inc = (gnt == PW'(N_VIRT_CHN-1)) ? '0 : gnt + PW'(1);

  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_vc     <= '0;
      valid_o     <= 1'b0;
      flit_data_o <= '0;
      vc_id_o     <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (out_free) valid_o <= acc;
      if (acc) begin
        flit_data_o <= flit;
        vc_id_o     <= gnt;
        if (state == IDLE) begin
          case (ftype)
            F_HEAD: begin
              state   <= LOCKED;
              lock_vc <= gnt;
            end
            F_HT:    rr_ptr <= gnt_inc;
            default: begin
              rr_ptr <= gnt_inc;
              err_o  <= 1'b1;
            end
          endcase
        end else begin
          case (ftype)
            F_BODY: ;
            F_TAIL: begin
              state  <= IDLE;
              rr_ptr <= gnt_inc;
            end
            F_HEAD: err_o <= 1'b1;
            default: begin
              state  <= IDLE;
              rr_ptr <= gnt_inc;
              err_o  <= 1'b1;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_vc_out_arbiter.sv
// Directed scoreboard bench for vc_out_arbiter with N_VIRT_CHN=2.

module tb_vc_out_arbiter;
  localparam int N  = 2;
  localparam int FW = 34;

  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, HT = 2'b11;

  typedef struct {
    logic [FW-1:0] d;
    logic          vc;
    logic          err;
  } item_t;

  logic            clk, arst, ready_i, valid_o, err_o;
  logic [N*FW-1:0] fin_data_i;
  logic [N-1:0]    fin_valid_i, fin_ready_o;
  logic [FW-1:0]   flit_data_o;
  logic [0:0]      vc_id_o;

  item_t    sb[$];
  logic          exp_valid, exp_err, exp_vc;
  logic [FW-1:0] exp_data;
  int n_chk, n_fail, seq;

  vc_out_arbiter #(.N_VIRT_CHN(N), .FLIT_WIDTH(FW)) dut (
    .clk(clk), .arst(arst), .fin_data_i(fin_data_i), .fin_valid_i(fin_valid_i),
    .fin_ready_o(fin_ready_o), .flit_data_o(flit_data_o), .valid_o(valid_o),
    .ready_i(ready_i), .vc_id_o(vc_id_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] ty, input int vc, input int s);
    logic [FW-3:0] pl;
    pl = (FW-2)'(32'h1000 * (vc + 1) + s);
    return {ty, pl};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(valid_o), 64'(exp_valid));
    chk({tag, ".err"}, 64'(err_o), 64'(exp_err));
    if (exp_valid) begin
      chk({tag, ".data"}, 64'(flit_data_o), 64'(exp_data));
      chk({tag, ".vc"}, 64'(vc_id_o), 64'(exp_vc));
    end
  endtask

  // Drive one cycle; er/ee are the expected ready vector and error for any accepted flit.
  task automatic step(input string tag, input logic [N-1:0] vld,
                      input logic [1:0] t0, input logic [1:0] t1,
                      input logic rdy, input logic [N-1:0] er, input logic ee);
    logic [FW-1:0] d0, d1;
    logic [N-1:0]  accv;
    item_t it;
    bit pushed;
    seq++;
    d0 = mk(t0, 0, seq);
    d1 = mk(t1, 1, seq);
    fin_valid_i = vld;
    fin_data_i  = {d1, d0};
    ready_i     = rdy;
    #1;
    chk({tag, ".ready"}, 64'(fin_ready_o), 64'(er));
    accv   = er & vld;
    pushed = 1'b0;
    if (accv != '0) begin
      it.d   = accv[1] ? d1 : d0;
      it.vc  = accv[1];
      it.err = ee;
      sb.push_back(it);
      pushed = 1'b1;
    end
    @(posedge clk);
    if (pushed) begin
      it        = sb.pop_front();
      exp_valid = 1'b1;
      exp_data  = it.d;
      exp_vc    = it.vc;
      exp_err   = it.err;
    end else begin
      if (rdy) exp_valid = 1'b0;
      exp_err = 1'b0;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    arst        = 1'b1;
    fin_valid_i = '1;
    fin_data_i  = {mk(H, 1, 0), mk(H, 0, 0)};
    ready_i     = 1'b1;
    repeat (2) begin
      #1;
      chk({tag, ".ready"}, 64'(fin_ready_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".valid"}, 64'(valid_o), 64'd0);
      chk({tag, ".err"}, 64'(err_o), 64'd0);
      chk({tag, ".data"}, 64'(flit_data_o), 64'd0);
      chk({tag, ".vc"}, 64'(vc_id_o), 64'd0);
    end
    arst      = 1'b0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    sb.delete();
  endtask

  initial begin
    n_chk = 0; n_fail = 0; seq = 0;
    exp_valid = 1'b0; exp_err = 1'b0; exp_vc = 1'b0; exp_data = '0;
    do_reset("rst");

    // Round-robin over single-flit packets
    step("rr0", 2'b11, HT, HT, 1'b1, 2'b01, 1'b0);
    step("rr1", 2'b11, HT, HT, 1'b1, 2'b10, 1'b0);
    step("rr2", 2'b11, HT, HT, 1'b1, 2'b01, 1'b0);
    step("rr3", 2'b11, HT, HT, 1'b1, 2'b10, 1'b0);

    // Wormhole: VC0 packet stays contiguous while VC1 waits with a HEAD
    step("wh_h", 2'b11, H, H, 1'b1, 2'b01, 1'b0);
    step("wh_b1", 2'b11, B, H, 1'b1, 2'b01, 1'b0);
    step("wh_b2", 2'b11, B, H, 1'b1, 2'b01, 1'b0);
    step("wh_t", 2'b11, T, H, 1'b1, 2'b01, 1'b0);
    step("wh_vc1h", 2'b11, H, H, 1'b1, 2'b10, 1'b0);
    step("wh_vc1b", 2'b11, H, B, 1'b1, 2'b10, 1'b0);

    // Back-pressure mid-packet, then drain and refill in the same cycle
    step("bp0", 2'b11, H, B, 1'b0, 2'b00, 1'b0);
    step("bp1", 2'b11, H, B, 1'b0, 2'b00, 1'b0);
    step("bp2", 2'b11, H, B, 1'b0, 2'b00, 1'b0);
    step("bp_rel", 2'b11, H, B, 1'b1, 2'b10, 1'b0);
    step("bp_t", 2'b10, H, T, 1'b1, 2'b10, 1'b0);

    // Violations: BODY in IDLE, then HEAD while locked
    step("v_body", 2'b10, H, B, 1'b1, 2'b10, 1'b1);
    step("v_head0", 2'b11, H, H, 1'b1, 2'b01, 1'b0);
    step("v_head1", 2'b01, H, H, 1'b1, 2'b01, 1'b1);
    step("v_lock_nv", 2'b10, H, H, 1'b1, 2'b01, 1'b0);
    step("v_body0", 2'b11, B, H, 1'b1, 2'b01, 1'b0);
    step("v_tail0", 2'b11, T, H, 1'b1, 2'b01, 1'b0);

    // Reset mid-packet drops the VC1 lock
    step("mr_h1", 2'b10, H, H, 1'b1, 2'b10, 1'b0);
    do_reset("mr_rst");
    step("mr_ht0", 2'b11, HT, B, 1'b1, 2'b01, 1'b0);
    step("mr_idle", 2'b00, HT, B, 1'b1, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
